button_debounce_array: RTL

- Parametrised multi-channel successor to the single-button debouncer.
- Debounces CHANNELS asynchronous push-button inputs against one shared slow sample tick.
- Per channel it provides:
  - a stable level;
  - one-cycle press and release pulses;
  - optional hold-to-auto-repeat pulses.
- Sits between board buttons/keypad lines and the game/entry FSMs.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 133 +++++++++++++
 rtl/button_debounce_array.sv | 64 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_HOLD = 2'd1,
    RPT_RPT  = 2'd2
  } rpt_state_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, tick-sampled stability counter,
// registered press/release pulses and optional hold-to-repeat FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS  = 2,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_raw,
  input  logic tick,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int SW = cnt_width(STABLE_TICKS);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    meta_d    = in_raw;
    sync_d    = meta_q;
    level_d   = level_q;
    scnt_d    = scnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      if (sync_q == level_q) begin
        scnt_d = '0;
      end else if (scnt_q == SW'(STABLE_TICKS - 1)) begin
        level_d   = ~level_q;
        scnt_d    = '0;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      level_q   <= 1'b0;
      scnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      level_q   <= level_d;
      scnt_q    <= scnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    rpt_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repeat_q, repeat_d;

    // Edge events are taken from the same tick that moves the level, so a
    // release always wins over a repeat falling due on that tick.
    always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      if (release_d) begin
        state_d = RPT_IDLE;
        rcnt_d  = '0;
      end else if (press_d) begin
        state_d = RPT_HOLD;
        rcnt_d  = '0;
      end else if (tick) begin
        case (state_q)
          RPT_HOLD: begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              repeat_d = 1'b1;
              state_d  = RPT_RPT;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          RPT_RPT: begin
            if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
              repeat_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= RPT_IDLE;
        rcnt_q   <= '0;
        repeat_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        rcnt_q   <= rcnt_d;
        repeat_q <= repeat_d;
      end
    end

    assign repeat_pulse = repeat_q;
  end else begin : g_no_rpt
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/button_debounce_array.sv
// CHANNELS independent button debouncers sharing one slow sample tick.
// Tick period is CLK_DIV cycles; outputs are registered, no backpressure.
module button_debounce_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int CLK_DIV       = 250000,
  parameter int STABLE_TICKS  = 2,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                tick
);

  if (CHANNELS < 1 || CLK_DIV < 2 || STABLE_TICKS < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_debounce_array: illegal parameter value");
  end

  localparam int TW = $clog2(CLK_DIV);

  logic [TW-1:0] tcnt_q, tcnt_d;

  assign tick = (tcnt_q == TW'(CLK_DIV - 1));

  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + TW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_raw       (in[i]),
      .tick         (tick),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule
